// File: rtl/jive_csr_pkg.sv
// JiVe CSR sequencer shared types and constants.
// States, req_op encodings, CSR addresses and bus indices.
package jive_csr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_RD_HI,
    ST_CAP,
    ST_WR_LO,
    ST_WR_HI,
    ST_DONE
  } state_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h304;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB80;
  localparam logic [11:0] ADDR_INSTRET  = 12'hC80;

  localparam logic [5:0] IDX_MSTATUS = 6'h14;
  localparam logic [5:0] IDX_MIP     = 6'h1C;
  localparam logic [5:0] IDX_CYCLE   = 6'h20;
  localparam logic [5:0] IDX_INSTRET = 6'h28;

  // New half-word value from the old half and the operand half.
  function automatic logic [15:0] csr_new(
    input logic [1:0]  op,
    input logic [15:0] old,
    input logic [15:0] w
  );
    logic [15:0] v;
    case (op)
      OP_RS:   v = old | w;
      OP_RC:   v = old & ~w;
      default: v = w;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/jive_csr_amap.sv
// CSR address to CSR-bus index decoder.
// Flags legal addresses and the read-only (addr[11:10]=11) space.
module jive_csr_amap
  import jive_csr_pkg::*;
(
  input  logic [11:0] i_addr,
  output logic [5:0]  o_idx,
  output logic        o_legal,
  output logic        o_ro
);

  // Address match to index; unmapped addresses are illegal.
  always_comb begin
    o_idx   = '0;
    o_legal = 1'b0;
    o_ro    = (i_addr[11:10] == 2'b11);
    unique case (1'b1)
      (i_addr == ADDR_MSTATUS): begin
        o_idx   = IDX_MSTATUS;
        o_legal = 1'b1;
      end
      (i_addr == ADDR_MIP): begin
        o_idx   = IDX_MIP;
        o_legal = 1'b1;
      end
      (i_addr == ADDR_MCYCLE),
      (i_addr == ADDR_CYCLE): begin
        o_idx   = IDX_CYCLE;
        o_legal = 1'b1;
      end
      (i_addr == ADDR_MINSTRET),
      (i_addr == ADDR_INSTRET): begin
        o_idx   = IDX_INSTRET;
        o_legal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/jive_csr_seq.sv
// JiVe Zicsr access sequencer: two half-word reads, two writes.
// Option JIVE_CSR_ROCHK_EN: writes to the 0xC00 space are illegal.
module jive_csr_seq
  import jive_csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_rd_en,
  input  logic        req_wr_en,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_illegal,
  output logic        csr_rd,
  output logic        csr_wr,
  output logic        msw_sel,
  output logic [5:0]  csr_idx,
  output logic [15:0] csr_wdata,
  input  logic [15:0] csr_rdata
);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_op;
  logic [31:0] r_wdata;
  logic        r_wr_en;
  logic        r_rd;
  logic [5:0]  r_idx;
  logic [31:0] r_old;
  logic        r_illegal;

  logic [5:0]  w_idx;
  logic        w_legal;
  logic        w_ro;
  logic        w_ill;
  logic        w_need_rd;
  logic        w_acc;

  jive_csr_amap u_amap (
    .i_addr  (req_addr),
    .o_idx   (w_idx),
    .o_legal (w_legal),
    .o_ro    (w_ro)
  );

  assign w_acc = req_valid & (r_state == ST_IDLE);

`ifdef JIVE_CSR_ROCHK_EN
  assign w_ill = ~w_legal | (w_ro & req_wr_en);
`else
  logic w_unused_ro;
  assign w_unused_ro = w_ro;
  assign w_ill = ~w_legal;
`endif

  assign w_need_rd = ((req_op == OP_RW) || (req_op == OP_NONE))
                   ? req_rd_en : 1'b1;

  assign rsp_rdata   = r_old;
  assign rsp_illegal = r_illegal;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Request capture on accept, then old-value assembly from the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= OP_NONE;
      r_wdata   <= '0;
      r_wr_en   <= 1'b0;
      r_rd      <= 1'b0;
      r_idx     <= '0;
      r_old     <= '0;
      r_illegal <= 1'b0;
    end else if (w_acc) begin
      r_op      <= req_op;
      r_wdata   <= req_wdata;
      r_wr_en   <= req_wr_en & ~w_ill;
      r_rd      <= w_need_rd & ~w_ill;
      r_idx     <= w_ill ? 6'h00 : w_idx;
      r_old     <= '0;
      r_illegal <= w_ill;
    end else begin
      if (r_state == ST_RD_HI)
        r_old[15:0] <= csr_rdata;
      if ((r_state == ST_CAP) ||
          ((r_state == ST_WR_LO) && r_rd))
        r_old[31:16] <= csr_rdata;
    end
  end

  // Next state and Moore bus/handshake outputs.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    csr_rd    = 1'b0;
    csr_wr    = 1'b0;
    msw_sel   = 1'b0;
    csr_idx   = r_idx;
    csr_wdata = '0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        csr_idx   = '0;
        if (w_acc) begin
          if (w_ill)          w_next = ST_DONE;
          else if (w_need_rd) w_next = ST_RD_LO;
          else                w_next = ST_WR_LO;
        end
      end
      ST_RD_LO: begin
        csr_rd = 1'b1;
        w_next = ST_RD_HI;
      end
      ST_RD_HI: begin
        csr_rd  = 1'b1;
        msw_sel = 1'b1;
        w_next  = r_wr_en ? ST_WR_LO : ST_CAP;
      end
      ST_CAP: begin
        w_next = ST_DONE;
      end
      ST_WR_LO: begin
        csr_wr = r_wr_en;
        if (r_wr_en)
          csr_wdata = csr_new(r_op, r_old[15:0], r_wdata[15:0]);
        w_next = ST_WR_HI;
      end
      ST_WR_HI: begin
        csr_wr  = r_wr_en;
        msw_sel = 1'b1;
        if (r_wr_en)
          csr_wdata = csr_new(r_op, r_old[31:16], r_wdata[31:16]);
        w_next = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jive_csr_seq.sv
// Bench for jive_csr_seq: transaction-level CSR model, bus responder,
// per-cycle compare of all DUT outputs plus literal pins.
`timescale 1ns/1ps
module tb_jive_csr_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_rd_en;
  logic        req_wr_en;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;
  logic        csr_rd;
  logic        csr_wr;
  logic        msw_sel;
  logic [5:0]  csr_idx;
  logic [15:0] csr_wdata;
  logic [15:0] csr_rdata;

  jive_csr_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_rd_en   (req_rd_en),
    .req_wr_en   (req_wr_en),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_illegal (rsp_illegal),
    .csr_rd      (csr_rd),
    .csr_wr      (csr_wr),
    .msw_sel     (msw_sel),
    .csr_idx     (csr_idx),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        acc;
    logic        rdy;
    logic        rd;
    logic        wr;
    logic        msw;
    logic [5:0]  idx;
    logic [15:0] wd;
    logic        vld;
    logic        crsp;
    logic [31:0] rdata;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model [64];
  logic [31:0] bmem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  logic [31:0] h_rdata = '0;
  logic        h_ill = 1'b0;
  int          cyc_cnt = 0;
  int          last_lat = 0;
  logic [31:0] last_rdata = '0;
  logic        last_ill = 1'b0;
  logic [15:0] last_wlo = '0;
  logic [15:0] last_whi = '0;
  logic [5:0]  last_idx = '0;

  // CSR block stand-in: registered half-word reads, half-word writes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rdata <= '0;
    end else begin
      csr_rdata <= csr_rd ? (msw_sel ? bmem[csr_idx][31:16]
                                     : bmem[csr_idx][15:0]) : 16'h0;
      if (csr_wr) begin
        if (msw_sel) bmem[csr_idx][31:16] <= csr_wdata;
        else         bmem[csr_idx][15:0]  <= csr_wdata;
      end
      if (pl_en) bmem[pl_idx] <= pl_val;
    end
  end

  // Per-cycle compare against the expected cycle queue.
  always @(negedge clk) begin : cmp
    exp_t        e;
    logic [59:0] gv;
    logic [59:0] ev;
    if (q.size() > 0) begin
      e = q.pop_front();
    end else begin
      e = '0;
      e.rdy = 1'b1;
      e.crsp = 1'b1;
      e.rdata = h_rdata;
      e.ill = h_ill;
    end
    gv = {req_ready, csr_rd, csr_wr, msw_sel, csr_idx, csr_wdata,
          rsp_valid, (e.crsp ? rsp_rdata : e.rdata),
          (e.crsp ? rsp_illegal : e.ill)};
    ev = {e.rdy, e.rd, e.wr, e.msw, e.idx, e.wd,
          e.vld, e.rdata, e.ill};
    checks++;
    if (gv !== ev) begin
      failures++;
      $display("FAIL bus_cycle t=%0t got=%h exp=%h", $time, gv, ev);
    end
    if (e.acc) cyc_cnt = 0;
    else       cyc_cnt++;
    if (rsp_valid) begin
      last_lat   = cyc_cnt;
      last_rdata = rsp_rdata;
      last_ill   = rsp_illegal;
    end
    if (e.vld) begin
      h_rdata = e.rdata;
      h_ill   = e.ill;
    end
    if (csr_wr) begin
      if (msw_sel) last_whi = csr_wdata;
      else         last_wlo = csr_wdata;
    end
    if (csr_rd) last_idx = csr_idx;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [6:0] amap(input logic [11:0] a);
    case (a)
      12'h304:          return {1'b1, 6'h14};
      12'h344:          return {1'b1, 6'h1C};
      12'hB00, 12'hC00: return {1'b1, 6'h20};
      12'hB80, 12'hC80: return {1'b1, 6'h28};
      default:          return 7'h00;
    endcase
  endfunction

  // Expected cycles for one request, and the CSR model update.
  task automatic push_req(input logic [1:0] op, input logic [11:0] a,
                          input logic [31:0] w, input logic rd_en,
                          input logic wr_en);
    exp_t        e;
    logic [6:0]  m;
    logic [5:0]  ix;
    logic        ill;
    logic        rdn;
    logic [31:0] old;
    logic [31:0] nv;
    m   = amap(a);
    ix  = m[5:0];
    ill = !m[6];
`ifdef JIVE_CSR_ROCHK_EN
    if (wr_en && (a[11:10] == 2'b11)) ill = 1'b1;
`endif
    e = '0; e.acc = 1'b1; e.rdy = 1'b1; e.crsp = 1'b1;
    e.rdata = h_rdata; e.ill = h_ill;
    q.push_back(e);
    if (ill) begin
      e = '0; e.vld = 1'b1; e.crsp = 1'b1; e.ill = 1'b1;
      q.push_back(e);
      return;
    end
    rdn = (op == 2'b00 || op == 2'b01) ? rd_en : 1'b1;
    old = rdn ? model[ix] : 32'h0;
    case (op)
      2'b10:   nv = old | w;
      2'b11:   nv = old & ~w;
      default: nv = w;
    endcase
    if (rdn) begin
      e = '0; e.rd = 1'b1; e.idx = ix; q.push_back(e);
      e.msw = 1'b1; q.push_back(e);
    end
    if (wr_en) begin
      e = '0; e.wr = 1'b1; e.idx = ix; e.wd = nv[15:0]; q.push_back(e);
      e.msw = 1'b1; e.wd = nv[31:16]; q.push_back(e);
      model[ix] = nv;
    end else if (rdn) begin
      e = '0; e.idx = ix; q.push_back(e);
    end
    e = '0; e.idx = ix; e.vld = 1'b1; e.crsp = 1'b1; e.rdata = old;
    q.push_back(e);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] w, input logic rd_en,
                        input logic wr_en);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_addr = a;
    req_wdata = w; req_rd_en = rd_en; req_wr_en = wr_en;
    push_req(op, a, w, rd_en, wr_en);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 12'($urandom);
    req_wdata = $urandom;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    q.delete();
  endtask

  task automatic preload(input logic [5:0] ix, input logic [31:0] v);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = ix; pl_val = v;
    model[ix] = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [11:0] alist [6];
    logic [31:0] sv;
    logic [1:0]  op;
    logic        rde;
    logic        wre;
    logic [11:0] a;
    logic [31:0] w;
    alist[0] = 12'h304; alist[1] = 12'h344; alist[2] = 12'hB00;
    alist[3] = 12'hC00; alist[4] = 12'hB80; alist[5] = 12'hC80;
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = '0; req_addr = '0;
    req_wdata = '0; req_rd_en = 1'b0; req_wr_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, req_ready}, 1);
    chk("rst_valid", {31'h0, rsp_valid}, 0);
    chk("rst_idx", {26'h0, csr_idx}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    rst_n = 1'b1;

    preload(6'h14, 32'h0000_0080);
    preload(6'h1C, $urandom);
    preload(6'h20, $urandom);
    preload(6'h28, $urandom);

    do_req(2'b01, 12'h304, 32'h0000_0888, 1'b1, 1'b1);
    chk("rw_lat", last_lat, 5);
    chk("rw_rdata", last_rdata, 32'h0000_0080);
    chk("rw_wlo", {16'h0, last_wlo}, 32'h0888);
    chk("rw_whi", {16'h0, last_whi}, 32'h0000);
    chk("rw_idx", {26'h0, last_idx}, 32'h14);

    preload(6'h14, 32'h0000_0080);
    do_req(2'b10, 12'h304, 32'h0000_0008, 1'b1, 1'b1);
    chk("rs_wlo", {16'h0, last_wlo}, 32'h0088);
    chk("rs_rdata", last_rdata, 32'h0000_0080);
    do_req(2'b11, 12'h304, 32'h0000_0080, 1'b1, 1'b1);
    chk("rc_wlo", {16'h0, last_wlo}, 32'h0008);
    chk("rc_rdata", last_rdata, 32'h0000_0088);

    preload(6'h20, 32'h5678_1234);
    do_req(2'b10, 12'hB00, 32'h0, 1'b1, 1'b0);
    chk("ro_lat", last_lat, 4);
    chk("ro_rdata", last_rdata, 32'h5678_1234);
    preload(6'h28, 32'h9ABC_DEF0);
    do_req(2'b10, 12'hC80, 32'h0, 1'b1, 1'b0);
    chk("ro_idx", {26'h0, last_idx}, 32'h28);
    chk("ro_rdata2", last_rdata, 32'h9ABC_DEF0);

    do_req(2'b01, 12'h123, 32'hDEAD_BEEF, 1'b1, 1'b1);
    chk("ill_lat", last_lat, 1);
    chk("ill_flag", {31'h0, last_ill}, 1);
    chk("ill_rdata", last_rdata, 0);

    do_req(2'b01, 12'hC00, 32'hFFFF_FFFF, 1'b0, 1'b1);
`ifdef JIVE_CSR_ROCHK_EN
    chk("rochk_lat", last_lat, 1);
    chk("rochk_ill", {31'h0, last_ill}, 1);
`else
    chk("c00_lat", last_lat, 3);
    chk("c00_ill", {31'h0, last_ill}, 0);
    chk("c00_wlo", {16'h0, last_wlo}, 32'hFFFF);
    chk("c00_whi", {16'h0, last_whi}, 32'hFFFF);
`endif

    sv = model[6'h1C];
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b01; req_addr = 12'h344;
    req_wdata = 32'h1357_9BDF; req_rd_en = 1'b1; req_wr_en = 1'b1;
    push_req(2'b01, 12'h344, 32'h1357_9BDF, 1'b1, 1'b1);
    model[6'h1C] = sv;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    chk("pre_rst_wr", {31'h0, csr_wr}, 1);
    rst_n = 1'b0;
    q.delete();
    h_rdata = '0;
    h_ill = 1'b0;
    #1;
    chk("arst_wr", {31'h0, csr_wr}, 0);
    chk("arst_rd", {31'h0, csr_rd}, 0);
    chk("arst_wdata", {16'h0, csr_wdata}, 0);
    chk("arst_idx", {26'h0, csr_idx}, 0);
    chk("arst_msw", {31'h0, msw_sel}, 0);
    chk("arst_ready", {31'h0, req_ready}, 1);
    chk("arst_valid", {31'h0, rsp_valid}, 0);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    do_req(2'b10, 12'h344, 32'h0000_F000, 1'b1, 1'b1);
    chk("post_rst_lat", last_lat, 5);
    chk("post_rst_rdata", last_rdata, sv);

    for (int i = 0; i < 300; i++) begin
      op  = 2'($urandom);
      rde = 1'($urandom);
      wre = (op == 2'b00 || op == 2'b01) ? 1'b1 : 1'($urandom);
      a   = ($urandom_range(0, 9) < 8) ? alist[$urandom_range(0, 5)]
                                      : 12'($urandom);
      w   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
      end
      do_req(op, a, w, rde, wre);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
